nor2buf_exerciser: RTL and testbench

Self-checking stimulus driver for the NOR2-plus-buffer cell (X = ~(A1|A2), Y = X, with B1/B2/C1 unused).
- Drives the cell's inputs through a fixed 8-step sequence and samples X/Y after a settle window.
- Counts mismatches and reports pass/fail per step.
- Sits beside the cell in a bring-up or BIST wrapper and is the active counterpart of the cell's passive assertion monitor.

---
 rtl/nor2buf_exerciser.sv | 192 +++++++++++++++++++
 tb/tb_nor2buf_exerciser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nor2buf_exerciser.sv
// Stimulus driver and checker for a NOR2-plus-buffer cell (X = ~(A1|A2), Y = X).
// Walks an 8-step drive table, samples X/Y after a settle window, and
// accumulates a saturating error count plus a per-step failure vector.
// A rail fault during a run aborts it.
module nor2buf_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 vpwr,
  input  logic                 vgnd,
  output logic                 a1,
  output logic                 a2,
  output logic                 b1,
  output logic                 b2,
  output logic                 c1,
  input  logic                 x,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 aborted,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE,
    S_ABORT
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [2:0] step;
  logic [3:0] loop;
  logic [7:0] settle_cnt;
  logic       base_x;
  logic       base_y;

  logic       rail_ok;
  logic       settle_last;
  logic       last_step;
  logic       nom;
  logic       mismatch;

  assign rail_ok     = vpwr & ~vgnd;
  assign settle_last = (settle_cnt == 8'(SETTLE_CYCLES - 1));
  assign last_step   = (step == 3'd7) && (loop == 4'(LOOPS - 1));

  // Nominal NOR output for the A values of the current step.
  assign nom = ~(step[2] | step[1]);

  // Base steps compare against the nominal value. Toggle steps must also
  // reproduce the base-step sample, so B/C sensitivity is caught even when
  // the base step itself already failed.
  always_comb begin
    mismatch = (x != nom) || (y != nom);
    if (step[0]) begin
      mismatch = mismatch || (x != base_x) || (y != base_y);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; rail faults take priority over everything in a run.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!rail_ok) begin
          state_nx = S_ABORT;
        end else if (settle_last) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!rail_ok) begin
          state_nx = S_ABORT;
        end else if (last_step) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_SETTLE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ABORT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs: drive values come straight from the step index while a
  // run is active (including the DONE cycle), and are zero otherwise.
  always_comb begin
    a1   = 1'b0;
    a2   = 1'b0;
    b1   = 1'b0;
    b2   = 1'b0;
    c1   = 1'b0;
    busy = (state != S_IDLE);
    done = (state == S_DONE) || (state == S_ABORT);
    if ((state == S_SETTLE) || (state == S_CHECK) || (state == S_DONE)) begin
      a1 = step[2];
      a2 = step[1];
      b1 = step[0];
      b2 = step[0];
      c1 = step[0];
    end
  end

  // Run datapath: step/loop sequencing, settle timing and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      step       <= '0;
      loop       <= '0;
      settle_cnt <= '0;
      base_x     <= 1'b0;
      base_y     <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      pass       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            step       <= '0;
            loop       <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
            aborted    <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (rail_ok) begin
            settle_cnt <= settle_last ? 8'd0 : settle_cnt + 8'd1;
          end
        end
        S_CHECK: begin
          if (rail_ok) begin
            if (mismatch) begin
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
              fail_vec[step] <= 1'b1;
            end
            if (!step[0]) begin
              base_x <= x;
              base_y <= y;
            end
            settle_cnt <= '0;
            if (step != 3'd7) begin
              step <= step + 3'd1;
            end else if (loop != 4'(LOOPS - 1)) begin
              loop <= loop + 4'd1;
              step <= '0;
            end
          end
        end
        S_DONE: begin
          pass <= (err_count == '0);
        end
        S_ABORT: begin
          aborted <= 1'b1;
          pass    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nor2buf_exerciser.sv
// Bench for nor2buf_exerciser: two instances with different parameters, each
// facing a cell model whose X/Y can be corrupted per step by fault masks.
module tb_nor2buf_exerciser;

  localparam int S0 = 2;
  localparam int L0 = 1;
  localparam int W0 = 8;
  localparam int S1 = 1;
  localparam int L1 = 2;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vpwr = 1'b1;
  logic start_0 = 1'b0, vgnd_0 = 1'b0;
  logic start_1 = 1'b0, vgnd_1 = 1'b0;

  logic a1_0, a2_0, b1_0, b2_0, c1_0, x_0, y_0, busy_0, done_0, pass_0, aborted_0;
  logic [W0-1:0] err_count_0;
  logic [7:0] fail_vec_0;
  logic a1_1, a2_1, b1_1, b2_1, c1_1, x_1, y_1, busy_1, done_1, pass_1, aborted_1;
  logic [W1-1:0] err_count_1;
  logic [7:0] fail_vec_1;

  // Fault masks indexed by {a1,a2,b1}: a set bit inverts that output for that step.
  logic [7:0] fx_0 = '0, fy_0 = '0, fx_1 = '0, fy_1 = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign x_0 = ~(a1_0 | a2_0) ^ fx_0[{a1_0, a2_0, b1_0}];
  assign y_0 = ~(a1_0 | a2_0) ^ fy_0[{a1_0, a2_0, b1_0}];
  assign x_1 = ~(a1_1 | a2_1) ^ fx_1[{a1_1, a2_1, b1_1}];
  assign y_1 = ~(a1_1 | a2_1) ^ fy_1[{a1_1, a2_1, b1_1}];

  nor2buf_exerciser #(.SETTLE_CYCLES(S0), .LOOPS(L0), .ERR_CNT_W(W0)) dut0 (
    .clk(clk), .rst(rst), .start(start_0), .vpwr(vpwr), .vgnd(vgnd_0),
    .a1(a1_0), .a2(a2_0), .b1(b1_0), .b2(b2_0), .c1(c1_0), .x(x_0), .y(y_0),
    .busy(busy_0), .done(done_0), .pass(pass_0), .aborted(aborted_0),
    .err_count(err_count_0), .fail_vec(fail_vec_0)
  );

  nor2buf_exerciser #(.SETTLE_CYCLES(S1), .LOOPS(L1), .ERR_CNT_W(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start_1), .vpwr(vpwr), .vgnd(vgnd_1),
    .a1(a1_1), .a2(a2_1), .b1(b1_1), .b2(b2_1), .c1(c1_1), .x(x_1), .y(y_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .aborted(aborted_1),
    .err_count(err_count_1), .fail_vec(fail_vec_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected result after the first nsteps checks of a run: a base step fails
  // if its own outputs are wrong; a toggle step fails if its outputs are
  // wrong or differ from the base-step sample (i.e. the base step was wrong).
  function automatic void expect_result(input logic [7:0] fx, input logic [7:0] fy,
                                        input int nsteps, input int w,
                                        output logic [7:0] fv, output int ec);
    int raw = 0;
    int lim = (1 << w) - 1;
    logic [7:0] mx = fx;
    logic [7:0] my = fy;
    fv = '0;
    for (int k = 0; k < nsteps; k++) begin
      int s = k % 8;
      logic f = mx[s] | my[s];
      if (s % 2 == 1) f = f | mx[s-1] | my[s-1];
      if (f) begin
        raw++;
        fv[s] = 1'b1;
      end
    end
    ec = (raw > lim) ? lim : raw;
  endfunction

  function automatic logic [4:0] drives_for(input int s);
    logic [2:0] v = 3'(s);
    return {v[2], v[1], v[0], v[0], v[0]};
  endfunction

  // One dut0 run; abort_at/rst_at (cycles after start edge, -1 = off) inject a
  // rail fault or a reset so that it is sampled at the following edge.
  task automatic run0(input logic [7:0] fx, input logic [7:0] fy,
                      input int abort_at, input int rst_at);
    logic [7:0] fv;
    int ec;
    bit ended = 0;
    int run_len = 8 * (S0 + 1) * L0;
    @(negedge clk);
    fx_0 = fx;
    fy_0 = fy;
    start_0 = 1'b1;
    @(posedge clk); #1;
    start_0 = 1'b0;
    check("start_busy", busy_0, 1);
    check("start_err", err_count_0, 0);
    check("start_drv", {a1_0, a2_0, b1_0, b2_0, c1_0}, drives_for(0));
    for (int t = 1; t <= 200; t++) begin
      @(posedge clk); #1;
      if (rst_at >= 0 && t == rst_at + 1) begin
        check("rst_outs", {a1_0, a2_0, b1_0, b2_0, c1_0, busy_0, done_0, pass_0, aborted_0}, 0);
        check("rst_err", err_count_0, 0);
        check("rst_fv", fail_vec_0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_nodone", {done_0, busy_0}, 0);
        ended = 1;
        break;
      end
      if (abort_at >= 0 && t == abort_at + 1) begin
        check("abort_done", done_0, 1);
        check("abort_drv", {a1_0, a2_0, b1_0, b2_0, c1_0}, 0);
        vgnd_0 = 1'b0;
        start_0 = 1'b1;
        @(posedge clk); #1;
        start_0 = 1'b0;
        expect_result(fx, fy, (abort_at / (S0 + 1)), W0, fv, ec);
        check("abort_idle", {busy_0, done_0}, 0);
        check("abort_flag", {aborted_0, pass_0}, 2'b10);
        check("abort_err", err_count_0, ec);
        check("abort_fv", fail_vec_0, fv);
        ended = 1;
        break;
      end
      if (done_0) begin
        check("run_len", t, run_len);
        start_0 = 1'b1;
        @(posedge clk); #1;
        start_0 = 1'b0;
        expect_result(fx, fy, 8 * L0, W0, fv, ec);
        check("end_idle", {busy_0, done_0, a1_0, a2_0, b1_0, b2_0, c1_0}, 0);
        check("end_pass", pass_0, (ec == 0));
        check("end_abort", aborted_0, 0);
        check("end_err", err_count_0, ec);
        check("end_fv", fail_vec_0, fv);
        ended = 1;
        break;
      end
      check("run_busy", busy_0, 1);
      check("run_drv", {a1_0, a2_0, b1_0, b2_0, c1_0}, drives_for((t / (S0 + 1)) % 8));
      if (t == 6) start_0 = 1'b0;
      if (t == 5) start_0 = 1'b1;
      if (abort_at >= 0 && t == abort_at) vgnd_0 = 1'b1;
      if (rst_at >= 0 && t == rst_at) rst = 1'b1;
    end
    if (!ended) check("run0_timeout", 0, 1);
  endtask

  task automatic run1(input logic [7:0] fx, input logic [7:0] fy);
    logic [7:0] fv;
    int ec;
    bit ended = 0;
    @(negedge clk);
    fx_1 = fx;
    fy_1 = fy;
    start_1 = 1'b1;
    @(posedge clk); #1;
    start_1 = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      @(posedge clk); #1;
      if (done_1) begin
        check("run1_len", t, 8 * (S1 + 1) * L1);
        @(posedge clk); #1;
        expect_result(fx, fy, 8 * L1, W1, fv, ec);
        check("run1_busy", busy_1, 0);
        check("run1_pass", pass_1, (ec == 0));
        check("run1_err", err_count_1, ec);
        check("run1_fv", fail_vec_1, fv);
        ended = 1;
        break;
      end
    end
    if (!ended) check("run1_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs0", {a1_0, a2_0, b1_0, b2_0, c1_0, busy_0, done_0, pass_0, aborted_0}, 0);
    check("reset_err0", err_count_0, 0);
    check("reset_fv0", fail_vec_0, 0);
    check("reset_outs1", {busy_1, done_1, pass_1, aborted_1}, 0);
    rst = 1'b0;

    run0(8'h00, 8'h00, -1, -1);   // good cell
    run0(8'hFC, 8'hFC, -1, -1);   // X,Y stuck at 1
    run0(8'hAA, 8'hAA, -1, -1);   // X = ~(A1|A2)^B1
    run0(8'h00, 8'h00, -1, -1);   // pass recovers after a failing run
    for (int i = 0; i < 6; i++) begin
      run0(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, -1);
    end

    run1(8'hFC, 8'hFC);           // 12 errors, counter saturates at 7
    run1(8'h00, 8'h00);
    run1(8'h02, 8'h00);           // step 1 only, 2 loops -> 2
    for (int i = 0; i < 4; i++) begin
      run1(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    run0(8'h00, 8'h00, 3 * (S0 + 1), -1);          // ground fault in step 3 settle
    run0(8'h14, 8'h01, 3 * (S0 + 1) + 1, -1);      // fault with errors accumulated
    run0(8'hFC, 8'hFC, -1, 5 * (S0 + 1) + S0);      // reset during step 5 check
    run0(8'h00, 8'h00, -1, -1);
    run0(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
